// File: rtl/min_scan_pkg.sv
// rtl/min_scan_pkg.sv - shared types and constants for the minimum-scan sequencer
package min_scan_pkg;

    localparam int MAX_RD_LATENCY     = 4;
    localparam int ADDR_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic                          valid;
        logic                          first;
        logic [ADDR_WIDTH_DEFAULT-1:0] addr;
    } pipe_entry_t;

endpackage

// File: rtl/rd_align_pipe.sv
// rtl/rd_align_pipe.sv - delays read-issue entries by the memory read latency
module rd_align_pipe
    import min_scan_pkg::*;
#(
    parameter int  DEPTH   = 1,
    parameter type entry_t = pipe_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  entry_t in_i,
    output entry_t out_o,
    output logic   empty_o
);

    entry_t stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_o = stage_q[DEPTH-1];

    // True when nothing valid will be left after the next shift, so the
    // entry now at the output is the last one of the scan.
    always_comb begin
        empty_o = !in_i.valid;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (stage_q[i].valid) begin
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/min_scan_ctrl.sv
// rtl/min_scan_ctrl.sv - address sequencer for the min-search datapath; MIN_SCAN_CTRL_ABORT_EN adds Abort/Aborted
module min_scan_ctrl
    import min_scan_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int RD_LATENCY = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Start_Addr,
    input  logic [ADDR_WIDTH:0]   Length,
`ifdef MIN_SCAN_CTRL_ABORT_EN
    input  logic                  Abort,
    output logic                  Aborted,
`endif
    output logic                  Busy,
    output logic                  Done,
    output logic                  Empty,
    output logic                  Mem_Rd_En,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic                  Cmp_Valid,
    output logic                  Load_Min,
    output logic [ADDR_WIDTH-1:0] Data_Addr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

    typedef struct packed {
        logic                  valid;
        logic                  first;
        logic [ADDR_WIDTH-1:0] addr;
    } entry_t;

    scan_state_t           state_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [ADDR_WIDTH:0]   remain_q;
    logic                  rd_en_q;
    logic                  first_q;
    logic                  empty_q;
    logic                  abort_now;
    logic                  pipe_empty;
    entry_t                pipe_in;
    entry_t                pipe_out;

`ifdef MIN_SCAN_CTRL_ABORT_EN
    logic abort_seen_q;
    logic aborted_q;
    // Abort suppresses the read strobe in the very cycle it is raised.
    assign abort_now = Abort && (state_q == S_ISSUE);
    assign Aborted   = aborted_q;
`else
    assign abort_now = 1'b0;
`endif

    // remain_q counts reads still to issue after the one on Mem_Addr now.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            addr_cnt_q   <= '0;
            mem_addr_q   <= '0;
            remain_q     <= '0;
            rd_en_q      <= 1'b0;
            first_q      <= 1'b0;
            empty_q      <= 1'b0;
`ifdef MIN_SCAN_CTRL_ABORT_EN
            abort_seen_q <= 1'b0;
            aborted_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
`ifdef MIN_SCAN_CTRL_ABORT_EN
                        abort_seen_q <= 1'b0;
                        aborted_q    <= 1'b0;
`endif
                        if (Length == '0) begin
                            empty_q <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            empty_q    <= 1'b0;
                            rd_en_q    <= 1'b1;
                            first_q    <= 1'b1;
                            mem_addr_q <= Start_Addr;
                            addr_cnt_q <= Start_Addr + ADDR_ONE;
                            remain_q   <= Length - LEN_ONE;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    first_q <= 1'b0;
                    if (abort_now) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
`ifdef MIN_SCAN_CTRL_ABORT_EN
                        abort_seen_q <= 1'b1;
`endif
                    end else if (remain_q == '0) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        mem_addr_q <= addr_cnt_q;
                        addr_cnt_q <= addr_cnt_q + ADDR_ONE;
                        remain_q   <= remain_q - LEN_ONE;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state_q <= S_FINISH;
`ifdef MIN_SCAN_CTRL_ABORT_EN
                        aborted_q <= abort_seen_q;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Mem_Rd_En = rd_en_q && !abort_now;
    assign Mem_Addr  = mem_addr_q;
    assign Busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign Done      = (state_q == S_FINISH);
    assign Empty     = empty_q;

    assign pipe_in.valid = Mem_Rd_En;
    assign pipe_in.first = first_q;
    assign pipe_in.addr  = mem_addr_q;

    rd_align_pipe #(
        .DEPTH   (RD_LATENCY),
        .entry_t (entry_t)
    ) u_rd_align_pipe (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .in_i    (pipe_in),
        .out_o   (pipe_out),
        .empty_o (pipe_empty)
    );

    assign Cmp_Valid = pipe_out.valid;
    assign Load_Min  = pipe_out.valid && pipe_out.first;
    assign Data_Addr = pipe_out.addr;

endmodule

// File: tb/tb_min_scan_ctrl.sv
// tb/tb_min_scan_ctrl.sv - directed self-checking bench for min_scan_ctrl at read latencies 1 and 3
module tb_min_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] sa;
    logic [8:0] len;
    int         n_cmp = 0;
    int         n_err = 0;
    int         sel   = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       empty;
        logic       rd;
        logic       cmp;
        logic       load;
        logic [7:0] maddr;
        logic [7:0] daddr;
    } obs_t;

    logic       busy1, done1, empty1, rd1, cmp1, load1;
    logic [7:0] maddr1, daddr1;
    logic       busy3, done3, empty3, rd3, cmp3, load3;
    logic [7:0] maddr3, daddr3;
    obs_t       o1, o3, ob;

`ifdef MIN_SCAN_CTRL_ABORT_EN
    logic abort;
    logic aborted1, aborted3;
`endif

    min_scan_ctrl #(.ADDR_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
        .Clk(clk), .Rst(rst), .Start(start), .Start_Addr(sa), .Length(len),
`ifdef MIN_SCAN_CTRL_ABORT_EN
        .Abort(abort), .Aborted(aborted1),
`endif
        .Busy(busy1), .Done(done1), .Empty(empty1), .Mem_Rd_En(rd1), .Mem_Addr(maddr1),
        .Cmp_Valid(cmp1), .Load_Min(load1), .Data_Addr(daddr1)
    );

    min_scan_ctrl #(.ADDR_WIDTH(8), .RD_LATENCY(3)) u_dut3 (
        .Clk(clk), .Rst(rst), .Start(start), .Start_Addr(sa), .Length(len),
`ifdef MIN_SCAN_CTRL_ABORT_EN
        .Abort(abort), .Aborted(aborted3),
`endif
        .Busy(busy3), .Done(done3), .Empty(empty3), .Mem_Rd_En(rd3), .Mem_Addr(maddr3),
        .Cmp_Valid(cmp3), .Load_Min(load3), .Data_Addr(daddr3)
    );

    assign o1 = '{busy1, done1, empty1, rd1, cmp1, load1, maddr1, daddr1};
    assign o3 = '{busy3, done3, empty3, rd3, cmp3, load3, maddr3, daddr3};
    assign ob = (sel != 0) ? o3 : o1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic chk_all_zero(input string tag, input obs_t o);
        chk({tag, "_busy"},  32'(o.busy),  32'd0);
        chk({tag, "_done"},  32'(o.done),  32'd0);
        chk({tag, "_empty"}, 32'(o.empty), 32'd0);
        chk({tag, "_rd"},    32'(o.rd),    32'd0);
        chk({tag, "_cmp"},   32'(o.cmp),   32'd0);
        chk({tag, "_load"},  32'(o.load),  32'd0);
        chk({tag, "_maddr"}, 32'(o.maddr), 32'd0);
        chk({tag, "_daddr"}, 32'(o.daddr), 32'd0);
    endtask

    // Start issued in cycle 0; reads cycles 1..n, compares 1+lat..n+lat, Done n+lat+1.
    task automatic run_scan(input logic [7:0] a, input int n, input int lat);
        logic [7:0] ea;
        start = 1'b1;
        sa    = a;
        len   = n[8:0];
        for (int c = 1; c <= n + lat + 1; c++) begin
            step();
            start = 1'b0;
            chk("rd", 32'(ob.rd), 32'(c <= n));
            if (c <= n) begin
                ea = a + 8'(c - 1);
                chk("maddr", 32'(ob.maddr), 32'(ea));
            end
            chk("cmp", 32'(ob.cmp), 32'((c > lat) && (c <= n + lat)));
            if ((c > lat) && (c <= n + lat)) begin
                ea = a + 8'(c - 1 - lat);
                chk("daddr", 32'(ob.daddr), 32'(ea));
            end
            chk("load", 32'(ob.load), 32'(c == lat + 1));
            chk("busy", 32'(ob.busy), 32'(c <= n + lat));
            chk("done", 32'(ob.done), 32'(c == n + lat + 1));
        end
        chk("empty_nonzero_len", 32'(ob.empty), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int seen_done;
        int n_pulses;
        rst   = 1'b1;
        start = 1'b0;
        sa    = '0;
        len   = '0;
`ifdef MIN_SCAN_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        idle(2);
        chk_all_zero("reset_l1", o1);
        chk_all_zero("reset_l3", o3);
        rst = 1'b0;
        idle(2);

        sel = 0;
        run_scan(8'h10, 4, 1);
        idle(4);

        // Zero length: Done/Empty next cycle, Start held into FINISH is ignored
        start = 1'b1;
        sa    = 8'h22;
        len   = 9'd0;
        step();
        chk("len0_done",  32'(o1.done),  32'd1);
        chk("len0_empty", 32'(o1.empty), 32'd1);
        chk("len0_busy",  32'(o1.busy),  32'd0);
        chk("len0_rd",    32'(o1.rd),    32'd0);
        chk("len0_cmp",   32'(o1.cmp),   32'd0);
        step();
        start = 1'b0;
        chk("len0_after_done",  32'(o1.done),  32'd0);
        chk("len0_after_busy",  32'(o1.busy),  32'd0);
        chk("len0_after_rd",    32'(o1.rd),    32'd0);
        chk("len0_empty_held",  32'(o1.empty), 32'd1);
        step();
        chk("len0_finish_start_ignored", 32'(o1.busy), 32'd0);
        idle(4);

        run_scan(8'hFE, 4, 1);
        idle(4);

        sel = 1;
        run_scan(8'h20, 2, 3);
        idle(4);

        sel = 0;
        run_scan(8'h80, 256, 1);
        idle(4);

        // Restart attempt while busy, then asynchronous reset mid-scan
        start = 1'b1;
        sa    = 8'h50;
        len   = 9'd8;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        sa    = 8'h40;
        len   = 9'd3;
        step();
        start = 1'b0;
        chk("restart_ignored_maddr", 32'(o1.maddr), 32'h52);
        chk("restart_ignored_busy",  32'(o1.busy),  32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst_l1", o1);
        chk_all_zero("midrst_l3", o3);
        step();
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o1.done || o3.done || o1.busy || o3.busy) seen_done++;
        end
        chk("after_rst_quiet", 32'(seen_done), 32'd0);
        run_scan(8'h33, 3, 1);
        idle(4);

`ifdef MIN_SCAN_CTRL_ABORT_EN
        start = 1'b1;
        sa    = 8'h60;
        len   = 9'd8;
        n_pulses  = 0;
        seen_done = 0;
        step();
        start = 1'b0;
        chk("abort_rd_c1", 32'(o1.rd), 32'd1);
        step();
        chk("abort_rd_c2", 32'(o1.rd), 32'd1);
        if (o1.cmp) n_pulses++;
        step();
        abort = 1'b1;
        #1;
        chk("abort_rd_c3", 32'(o1.rd), 32'd0);
        if (o1.cmp) n_pulses++;
        for (int i = 0; i < 20 && seen_done == 0; i++) begin
            step();
            abort = 1'b0;
            chk("abort_no_more_rd", 32'(o1.rd), 32'd0);
            if (o1.cmp) n_pulses++;
            if (o1.done) begin
                seen_done = 1;
                chk("abort_aborted_flag", 32'(aborted1), 32'd1);
            end
        end
        chk("abort_done_seen", 32'(seen_done), 32'd1);
        chk("abort_cmp_pulses", 32'(n_pulses), 32'd2);
        idle(4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
